// File: rtl/atc_runway_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// atc_pkg
// Shared definitions for the runway scheduler:
//   - atc_state_e       : scheduler FSM states (IDLE, EVAL, HOLD)
//   - FUEL_* constants  : 2-bit fuel status codes carried on the request
//   - DEFAULT_*_HOLD    : default hold lengths in clock cycles
//   - helper functions  : fuel classification and an integer max used when
//                         sizing the hold timer
// ---------------------------------------------------------------------------
package atc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_HOLD = 2'd2
    } atc_state_e;

    localparam logic [1:0] FUEL_NORMAL = 2'b00;
    localparam logic [1:0] FUEL_SHORT  = 2'b01;
    localparam logic [1:0] FUEL_ALT    = 2'b10;  // second encoding of "normal"
    localparam logic [1:0] FUEL_EXCESS = 2'b11;

    localparam int DEFAULT_WEATHER_HOLD = 12;
    localparam int DEFAULT_FUEL_HOLD    = 15;

    // A fuel shortage promotes the request to priority traffic.
    function automatic logic fuel_is_priority(input logic [1:0] f);
        logic p;
        case (f)
            FUEL_SHORT:                          p = 1'b1;
            FUEL_NORMAL, FUEL_ALT, FUEL_EXCESS:  p = 1'b0;
            default:                             p = 1'b0;
        endcase
        return p;
    endfunction

    // Excess fuel on a landing forces one burn-off hold before a grant.
    function automatic logic fuel_needs_hold(input logic [1:0] f);
        return (f == FUEL_EXCESS);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/atc_runway_scheduler_occupancy.sv
// ---------------------------------------------------------------------------
// runway_occupancy_timer
// Tracks how long one runway stays occupied after it has been granted.
// A load pulse (re)starts an OCCUPY_CYCLES down-counter; the runway reports
// busy for exactly OCCUPY_CYCLES cycles, starting in the cycle after the
// load edge.
// Ports:
//   clk_i   in   clock, rising edge
//   rst_i   in   asynchronous active-high reset (clears occupancy)
//   load_i  in   one-cycle pulse: runway granted on this edge
//   busy_o  out  runway currently occupied
// ---------------------------------------------------------------------------
module runway_occupancy_timer #(
    parameter  int OCCUPY_CYCLES = 8,
    localparam int CNT_W         = $clog2(OCCUPY_CYCLES + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    output logic busy_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(OCCUPY_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/atc_runway_scheduler.sv
// ---------------------------------------------------------------------------
// atc_runway_scheduler
// Accepts one landing/takeoff request at a time, applies priority and
// weather/fuel holds, and grants a free runway with a one-cycle pulse.
// Per-runway occupancy timers guarantee a runway is never double-granted.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE (and low while
// reset is asserted); the request fields are sampled on that edge only and
// may change freely afterwards. The grant is a single-cycle pulse with no
// back-pressure.
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   asynchronous active-high reset
//   req_valid      in   request present
//   req_ready      out  scheduler can accept a request (IDLE)
//   req_takeoff    in   0 = landing, 1 = takeoff
//   emergency      in   priority flag, latched at accept and watched live
//   weather_ok     in   live weather status, 1 = good
//   fuel           in   fuel status code (see atc_pkg), latched at accept
//   gate_number    in   departure gate, latched at accept
//   grant_valid    out  one-cycle grant pulse
//   grant_runway   out  granted runway index, valid with grant_valid
//   grant_takeoff  out  request type of the grant, valid with grant_valid
//   timer_active   out  a hold is in progress
//   timer_value    out  remaining hold cycles
//   runway_busy    out  per-runway occupancy
//   dbg_state      out  current FSM state (atc_state_e encoding)
// ---------------------------------------------------------------------------
module atc_runway_scheduler
    import atc_pkg::*;
#(
    parameter  int NUM_RUNWAYS   = 4,
    parameter  int GATE_W        = 3,
    parameter  int WEATHER_HOLD  = DEFAULT_WEATHER_HOLD,
    parameter  int FUEL_HOLD     = DEFAULT_FUEL_HOLD,
    parameter  int OCCUPY_CYCLES = 8,
    localparam int RW_W          = $clog2(NUM_RUNWAYS),
    localparam int TIMER_W       = $clog2(max_int(WEATHER_HOLD, FUEL_HOLD) + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_takeoff,
    input  logic                   emergency,
    input  logic                   weather_ok,
    input  logic [1:0]             fuel,
    input  logic [GATE_W-1:0]      gate_number,
    output logic                   grant_valid,
    output logic [RW_W-1:0]        grant_runway,
    output logic                   grant_takeoff,
    output logic                   timer_active,
    output logic [TIMER_W-1:0]     timer_value,
    output logic [NUM_RUNWAYS-1:0] runway_busy,
    output logic [1:0]             dbg_state
);

    atc_state_e          state_q, state_d;

    logic                lat_takeoff_q;
    logic                lat_emerg_q;
    logic [1:0]          lat_fuel_q;
    logic [GATE_W-1:0]   lat_gate_q;
    logic                fuel_hold_done_q, fuel_hold_done_d;

    logic [TIMER_W-1:0]  timer_q, timer_d;

    logic                grant_valid_q, grant_valid_d;
    logic [RW_W-1:0]     grant_runway_q, grant_runway_d;
    logic                grant_takeoff_q;

    logic                accept;
    logic                priority_req;
    logic [NUM_RUNWAYS-1:0] busy;
    logic [NUM_RUNWAYS-1:0] load;

    // Candidate searches over the registered busy bits.
    logic                any_found;   // lowest free runway, including 0
    logic [RW_W-1:0]     any_idx;
    logic                alt_found;   // lowest free runway in 1..N-1
    logic [RW_W-1:0]     alt_idx;
    logic                pref_ok;     // gate-derived runway usable
    logic [RW_W-1:0]     pref_idx;

    assign priority_req = lat_emerg_q | emergency | fuel_is_priority(lat_fuel_q);

    always_comb begin
        any_found = 1'b0;
        any_idx   = '0;
        alt_found = 1'b0;
        alt_idx   = '0;
        pref_ok   = 1'b0;
        pref_idx  = '0;
        // Descending scans: the last hit is the lowest free index.
        for (int i = NUM_RUNWAYS - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                any_found = 1'b1;
                any_idx   = RW_W'(i);
            end
        end
        for (int i = NUM_RUNWAYS - 1; i >= 1; i--) begin
            if (!busy[i]) begin
                alt_found = 1'b1;
                alt_idx   = RW_W'(i);
            end
        end
        // The top RW_W gate bits select the preferred runway. Runway 0 is
        // never a takeoff preference, and out-of-range indices never match.
        for (int i = 1; i < NUM_RUNWAYS; i++) begin
            if (((lat_gate_q >> (GATE_W - RW_W)) == GATE_W'(i)) && !busy[i]) begin
                pref_ok  = 1'b1;
                pref_idx = RW_W'(i);
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        timer_d          = timer_q;
        fuel_hold_done_d = fuel_hold_done_q;
        grant_valid_d    = 1'b0;
        grant_runway_d   = '0;
        accept           = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    accept           = 1'b1;
                    fuel_hold_done_d = 1'b0;
                    state_d          = ST_EVAL;
                end
            end
            ST_EVAL: begin
                // First matching rule wins; a rule with no free candidate
                // leaves the FSM in EVAL to retry next cycle.
                if (priority_req) begin
                    if (any_found) begin
                        grant_valid_d  = 1'b1;
                        grant_runway_d = any_idx;
                    end
                end else if (!weather_ok) begin
                    state_d = ST_HOLD;
                    timer_d = TIMER_W'(WEATHER_HOLD);
                end else if (!lat_takeoff_q && fuel_needs_hold(lat_fuel_q) && !fuel_hold_done_q) begin
                    state_d          = ST_HOLD;
                    timer_d          = TIMER_W'(FUEL_HOLD);
                    fuel_hold_done_d = 1'b1;
                end else if (lat_takeoff_q) begin
                    if (pref_ok) begin
                        grant_valid_d  = 1'b1;
                        grant_runway_d = pref_idx;
                    end else if (alt_found) begin
                        grant_valid_d  = 1'b1;
                        grant_runway_d = alt_idx;
                    end
                end else if (alt_found) begin
                    grant_valid_d  = 1'b1;
                    grant_runway_d = alt_idx;
                end
                if (grant_valid_d) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                // A live emergency cuts the hold short; otherwise the hold
                // ends on the edge where the timer steps 1 -> 0.
                if (emergency || (timer_q <= TIMER_W'(1))) begin
                    timer_d = '0;
                    state_d = ST_EVAL;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            timer_q          <= '0;
            fuel_hold_done_q <= 1'b0;
            grant_valid_q    <= 1'b0;
            grant_runway_q   <= '0;
            grant_takeoff_q  <= 1'b0;
            lat_takeoff_q    <= 1'b0;
            lat_emerg_q      <= 1'b0;
            lat_fuel_q       <= '0;
            lat_gate_q       <= '0;
        end else begin
            state_q          <= state_d;
            timer_q          <= timer_d;
            fuel_hold_done_q <= fuel_hold_done_d;
            grant_valid_q    <= grant_valid_d;
            grant_runway_q   <= grant_runway_d;
            grant_takeoff_q  <= grant_valid_d & lat_takeoff_q;
            if (accept) begin
                lat_takeoff_q <= req_takeoff;
                lat_emerg_q   <= emergency;
                lat_fuel_q    <= fuel;
                lat_gate_q    <= gate_number;
            end
        end
    end

    // The grant edge also starts the runway's occupancy window, so the
    // runway reads busy in the same cycle grant_valid is high.
    for (genvar r = 0; r < NUM_RUNWAYS; r++) begin : g_runway
        assign load[r] = grant_valid_d && (grant_runway_d == RW_W'(r));
        runway_occupancy_timer #(
            .OCCUPY_CYCLES(OCCUPY_CYCLES)
        ) u_occ (
            .clk_i (clk),
            .rst_i (reset),
            .load_i(load[r]),
            .busy_o(busy[r])
        );
    end

    assign req_ready     = (state_q == ST_IDLE) && !reset;
    assign grant_valid   = grant_valid_q;
    assign grant_runway  = grant_runway_q;
    assign grant_takeoff = grant_takeoff_q;
    assign timer_active  = (state_q == ST_HOLD);
    assign timer_value   = timer_q;
    assign runway_busy   = busy;
    assign dbg_state     = state_q;

endmodule

// File: doc/atc_runway_scheduler.md
Name: atc_runway_scheduler

Overview:
- Clocked, parametrised successor to the combinational AirTrafficControl allocator.
- Accepts one landing/takeoff request at a time through a valid/ready handshake.
- Applies emergency/fuel priority and weather/fuel hold timers, then grants one of NUM_RUNWAYS runways.
- Tracks per-runway occupancy so a runway is never double-granted. Sits between the radar/tower request front-end and the gate/runway display logic.

Parameters:
- NUM_RUNWAYS, 4: number of runways; must be ≥2. Runway 0 is reserved for priority traffic.
- GATE_W, 3: gate_number width; must be ≥ RW_W.
- WEATHER_HOLD, 12: hold cycles while weather is bad.
- FUEL_HOLD, 15: hold cycles for fuel-excess landings.
- OCCUPY_CYCLES, 8: cycles a granted runway stays busy.
- RW_W, derived as clog2(NUM_RUNWAYS): runway index width.
- TIMER_W, derived as clog2(max(WEATHER_HOLD, FUEL_HOLD)+1): timer width.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_takeoff  in  1  0 = landing, 1 = takeoff
- emergency  in  1  priority flag; latched at accept and also monitored live
- weather_ok  in  1  live weather status, 1 = good
- fuel  in  2  00 normal, 01 shortage, 10 normal, 11 excess; latched at accept
- gate_number  in  GATE_W  departure gate; latched at accept
- grant_valid  out  1  one-cycle grant pulse
- grant_runway  out  RW_W  granted runway, valid with grant_valid
- grant_takeoff  out  1  echo of the latched request type
- timer_active  out  1  high during HOLD
- timer_value  out  TIMER_W  remaining hold cycles
- runway_busy  out  NUM_RUNWAYS  per-runway occupancy

Behaviour:
- Reset (async, active-high): state = IDLE, all outputs 0, occupancy cleared, latched request discarded. A reset asserted mid-HOLD or mid-EVAL drops the request and produces no grant.
- States:
  - IDLE: req_ready = 1. On the edge where req_valid && req_ready, latch type, emergency, fuel and gate, clear fuel_hold_done, go to EVAL.
  - EVAL: evaluated every cycle, first matching rule wins:
    1. Priority (latched emergency, live emergency, or fuel == 01): pick runway 0 if free, else the lowest-index free runway. If none is free, stay in EVAL.
    2. Weather bad (!weather_ok): go to HOLD with timer loaded to WEATHER_HOLD.
    3. Landing with fuel == 11 and !fuel_hold_done: go to HOLD with timer loaded to FUEL_HOLD, set fuel_hold_done.
    4. Takeoff: preferred runway = gate_number >> (GATE_W−RW_W). If the preferred runway is 0 or busy, pick the lowest free runway in 1..NUM_RUNWAYS−1.
    5. Normal landing: lowest free runway in 1..NUM_RUNWAYS−1.
    - No candidate free: stay in EVAL and retry next cycle.
  - On selection: next edge sets grant_valid = 1 for exactly one cycle with grant_runway and grant_takeoff, marks that runway busy, and returns to IDLE. req_ready is high in the same cycle as grant_valid.
  - HOLD: timer_active = 1; timer_value decrements once per edge. On the edge where it goes 1→0, timer_active drops and state returns to EVAL, so the hold lasts exactly H cycles. Weather is re-checked in EVAL; repeated weather holds are allowed. A live emergency during HOLD aborts the hold (timer cleared) and goes to EVAL next edge.
- Latency: grant_valid asserts one cycle after the accept edge when no hold applies and a runway is free.
- Occupancy: a granted runway is busy for OCCUPY_CYCLES cycles, then freed. EVAL uses registered busy bits, so a runway that releases in the same cycle is not granted until the following cycle.
- fuel == 10 is treated as normal. Timer values never underflow.

Decomposition:
- Shared package atc_pkg:
  - state encoding: IDLE, EVAL, HOLD
  - fuel code constants: FUEL_NORMAL, FUEL_SHORT, FUEL_ALT, FUEL_EXCESS
  - default hold constants: 12, 15
- Sub-module runway_occupancy_timer, one instance per runway via generate.
  - Inputs: load pulse, OCCUPY_CYCLES down-counter.
  - Output: busy.
  - Same async active-high reset.

Test Plan (all at default parameters):
1. Emergency landing: req with emergency = 1, weather_ok = 0 → grant_valid one cycle after accept, grant_runway = 0, timer_active never high.
2. Bad weather: landing, fuel = 00, weather_ok = 0 → timer_active counts 12..1 for 12 cycles. Raise weather_ok at count 5 → grant on runway 1 after timer expiry. Keep weather bad instead → second 12-cycle hold.
3. Fuel excess: landing, fuel = 11, weather good → 15-cycle hold, then grant runway 1. Assert emergency at timer_value = 7 → hold aborts and grant on runway 0.
4. Takeoff gate mapping: gate 100 → runway 2; gate 110 → runway 3; gate 001 → runway 1 (preferred runway 0 redirected).
5. Contention: four back-to-back normal landings → runways 1, 2, 3 granted; fourth stalls in EVAL until runway 1 frees 8 cycles after its grant, then gets runway 1.
6. Reset mid-HOLD: assert reset at timer_value = 6 → all outputs 0 immediately, no grant, req_ready = 1 after release.
